// File: rtl/link_return_ctrl.sv
// Link-back return sequencer: latches LR on request, flushes fetch/decode for
// FLUSH_CYCLES unstalled cycles, then redirects fetch to LR through a ready handshake.
module link_return_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             link_back_i,
  input  logic [PC_W-1:0]  LR_i,
  input  logic             stall_i,
  input  logic             fetch_ready_i,
  output logic             pc_load_o,
  output logic [PC_W-1:0]  pc_target_o,
  output logic             flush_fetch_o,
  output logic             flush_decode_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ret_count_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_t;

  state_t           r_state, w_state_next;
  logic [PC_W-1:0]  r_target, w_target_next;
  logic [3:0]       r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_ret_count, w_ret_count_next;
  logic             r_err, w_err_next;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_cnt       <= '0;
      r_ret_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_cnt       <= w_cnt_next;
      r_ret_count <= w_ret_count_next;
      r_err       <= w_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_target_next    = r_target;
    w_cnt_next       = r_cnt;
    w_ret_count_next = r_ret_count;
    w_err_next       = r_err;
    case (r_state)
      ST_IDLE: begin
        if (link_back_i && !stall_i) begin
          w_target_next = LR_i & ~PC_W'(1);
          w_cnt_next    = 4'(FLUSH_CYCLES - 1);
          w_state_next  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (link_back_i) w_err_next = 1'b1;
        if (!stall_i) begin
          if (r_cnt == 4'd0) w_state_next = ST_REDIRECT;
          else               w_cnt_next   = r_cnt - 4'd1;
        end
      end
      ST_REDIRECT: begin
        // A request on the completing edge is re-evaluated in IDLE, not flagged.
        if (fetch_ready_i) begin
          w_state_next = ST_IDLE;
          if (r_ret_count != '1) w_ret_count_next = r_ret_count + CNT_W'(1);
        end else if (link_back_i) begin
          w_err_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign flush_fetch_o  = (r_state == ST_FLUSH);
  assign flush_decode_o = (r_state == ST_FLUSH);
  assign pc_load_o      = (r_state == ST_REDIRECT);
  assign pc_target_o    = (r_state == ST_REDIRECT) ? r_target : '0;
  assign busy_o         = (r_state != ST_IDLE);
  assign ret_count_o    = r_ret_count;
  assign err_o          = r_err;

endmodule

// File: tb/tb_link_return_ctrl.sv
// Self-checking bench for link_return_ctrl: transaction-level reference model,
// per-cycle compare, directed literal checks and randomized traffic.
module tb_link_return_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int PC_W         = 16;
  localparam int CNT_W        = 8;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             link_back_i = 1'b0;
  logic [PC_W-1:0]  LR_i = '0;
  logic             stall_i = 1'b0;
  logic             fetch_ready_i = 1'b0;
  logic             pc_load_o;
  logic [PC_W-1:0]  pc_target_o;
  logic             flush_fetch_o;
  logic             flush_decode_o;
  logic             busy_o;
  logic [CNT_W-1:0] ret_count_o;
  logic             err_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  link_return_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .link_back_i(link_back_i), .LR_i(LR_i),
    .stall_i(stall_i), .fetch_ready_i(fetch_ready_i), .pc_load_o(pc_load_o),
    .pc_target_o(pc_target_o), .flush_fetch_o(flush_fetch_o),
    .flush_decode_o(flush_decode_o), .busy_o(busy_o), .ret_count_o(ret_count_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a return is "flush budget remaining" followed by "load pending".
  int      m_flush_left = 0;
  bit      m_load       = 0;
  int      m_target     = 0;
  int      m_count      = 0;
  bit      m_err        = 0;

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      m_flush_left = 0; m_load = 0; m_target = 0; m_count = 0; m_err = 0;
    end else if (m_load) begin
      if (fetch_ready_i) begin
        m_load  = 0;
        m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
      end else if (link_back_i) m_err = 1;
    end else if (m_flush_left > 0) begin
      if (link_back_i) m_err = 1;
      if (!stall_i) begin
        m_flush_left--;
        if (m_flush_left == 0) m_load = 1;
      end
    end else if (link_back_i && !stall_i) begin
      m_target     = int'(LR_i) - (int'(LR_i) % 2);
      m_flush_left = FLUSH_CYCLES;
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      logic [PC_W-1:0] e_tgt;
      logic            e_flush;
      e_flush = (m_flush_left > 0);
      e_tgt   = m_load ? PC_W'(m_target) : '0;
      n_tests++;
      if (pc_load_o !== m_load || pc_target_o !== e_tgt || flush_fetch_o !== e_flush ||
          flush_decode_o !== e_flush || busy_o !== (e_flush || m_load) ||
          ret_count_o !== CNT_W'(m_count) || err_o !== m_err) begin
        n_fail++;
        $display("FAIL model t=%0t act load=%b tgt=%h ff=%b fd=%b busy=%b cnt=%0d err=%b exp load=%b tgt=%h flush=%b busy=%b cnt=%0d err=%b",
                 $time, pc_load_o, pc_target_o, flush_fetch_o, flush_decode_o, busy_o,
                 ret_count_o, err_o, m_load, e_tgt, e_flush, e_flush || m_load, m_count, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; link_back_i = 1'b0; stall_i = 1'b0; fetch_ready_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy_o === 1'b1 && k < 200) begin tick(); k++; end
    chk({name, "_timeout"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    chk("reset_cnt", 32'(ret_count_o), 32'd0);
    chk("reset_load", 32'(pc_load_o), 32'd0);

    // 1: basic return, LR=0x1235
    link_back_i = 1; LR_i = 16'h1235; fetch_ready_i = 1;
    tick(); link_back_i = 0; LR_i = 16'hABCD;
    chk("t1_flush_c1", 32'(flush_fetch_o), 32'd1);
    tick();
    chk("t1_flush_c2", 32'(flush_decode_o), 32'd1);
    tick();
    chk("t1_load_c3", 32'(pc_load_o), 32'd1);
    chk("t1_target", 32'(pc_target_o), 32'h1234);
    chk("t1_flush_off", 32'(flush_fetch_o), 32'd0);
    tick();
    chk("t1_count", 32'(ret_count_o), 32'd1);
    chk("t1_idle", 32'(busy_o), 32'd0);

    // 3: ready withheld for 4 cycles in REDIRECT
    link_back_i = 1; LR_i = 16'h1235; fetch_ready_i = 0;
    tick(); link_back_i = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_load_held", 32'(pc_load_o), 32'd1);
      chk("t3_tgt_held", 32'(pc_target_o), 32'h1234);
      if (i == 4) fetch_ready_i = 1;
      tick();
    end
    chk("t3_count", 32'(ret_count_o), 32'd2);

    // 4: link_back_i held through a whole sequence
    do_reset();
    link_back_i = 1; LR_i = 16'h0101; fetch_ready_i = 1;
    tick(); tick();
    chk("t4_err", 32'(err_o), 32'd1);
    tick(); tick(); tick();
    chk("t4_second_busy", 32'(busy_o), 32'd1);
    chk("t4_count_mid", 32'(ret_count_o), 32'd1);
    link_back_i = 0;
    tick(); tick(); tick();
    chk("t4_count", 32'(ret_count_o), 32'd2);

    // 5: reset during REDIRECT
    fetch_ready_i = 0; link_back_i = 1; LR_i = 16'hFFFF;
    tick(); link_back_i = 0; tick(); tick();
    chk("t5_tgt_ffff", 32'(pc_target_o), 32'hFFFE);
    rst_n_i = 0; tick(); rst_n_i = 1;
    chk("t5_load", 32'(pc_load_o), 32'd0);
    chk("t5_cnt", 32'(ret_count_o), 32'd0);
    chk("t5_err", 32'(err_o), 32'd0);

    // 6: counter saturation
    fetch_ready_i = 1;
    for (int r = 0; r < 260; r++) begin
      link_back_i = 1; LR_i = 16'(r);
      tick(); link_back_i = 0;
      wait_idle("t6");
    end
    chk("t6_sat", 32'(ret_count_o), 32'hFF);

    // Randomized traffic, including stalls and rare resets
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      link_back_i   = ($urandom_range(0, 99) < 30);
      stall_i       = ($urandom_range(0, 99) < 30);
      fetch_ready_i = ($urandom_range(0, 99) < 50);
      LR_i          = 16'($urandom);
      rst_n_i       = ($urandom_range(0, 999) >= 5);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
